// File: rtl/reg_serial_loader.sv
// reg_serial_loader: serialises parallel E/C/P values MSB-first onto the load/shift interface of reg_e/c/p.
// Define LOADER_READBACK_CHECK_EN to add a one-cycle readback compare (CHECK state) driving check_err.
module reg_serial_loader #(
    parameter int E_W = 24,
    parameter int C_W = 15,
    parameter int P_W = 9
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           req_valid,
    output logic           req_ready,
    input  logic [1:0]     req_sel,
    input  logic [E_W-1:0] req_e,
    input  logic [C_W-1:0] req_c,
    input  logic [P_W-1:0] req_p,
    output logic           load_e,
    output logic           load_c,
    output logic           load_p,
    output logic           shift_e,
    output logic           shift_c,
    output logic           shift_p,
    input  logic [E_W-1:0] out_e,
    input  logic [C_W-1:0] out_c,
    input  logic [P_W-1:0] out_p,
    output logic           busy,
    output logic           done,
    output logic           check_err
);
    localparam int MX = (E_W > C_W) ? ((E_W > P_W) ? E_W : P_W) : ((C_W > P_W) ? C_W : P_W);
    localparam int CW = $clog2(MX) + 1;
    localparam logic [CW-1:0] LE = CW'(E_W);
    localparam logic [CW-1:0] LC = CW'(C_W);
    localparam logic [CW-1:0] LP = CW'(P_W);
    localparam logic [CW-1:0] LM = CW'(MX);

    typedef enum logic [1:0] {IDLE, SHIFT, CHECK, DONE} state_t;

`ifdef LOADER_READBACK_CHECK_EN
    localparam state_t LAST = CHECK;
`else
    localparam state_t LAST = DONE;
`endif

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n, len;
    logic [1:0]      sel_q, sel_n;
    logic [E_W-1:0]  sr_e, src_e;
    logic [C_W-1:0]  sr_c, src_c;
    logic [P_W-1:0]  sr_p, src_p;
    logic            accept, sh_e_n, sh_c_n, sh_p_n;

    assign accept = req_valid && req_ready;
    assign sel_n  = accept ? req_sel : sel_q;
    assign src_e  = accept ? req_e : sr_e;
    assign src_c  = accept ? req_c : sr_c;
    assign src_p  = accept ? req_p : sr_p;
    assign len    = (sel_q == 2'd0) ? LE : (sel_q == 2'd1) ? LC : (sel_q == 2'd2) ? LP : LM;

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE:    if (accept) begin
                         state_n = SHIFT;
                         cnt_n   = CW'(1);
                     end
            SHIFT:   if (cnt == len) state_n = LAST;
                     else cnt_n = cnt + 1'b1;
            CHECK:   state_n = DONE;
            default: state_n = IDLE;
        endcase
        // Each channel is live for its own width only, so sel=3 ends the shorter ones early.
        sh_e_n = (state_n == SHIFT) && (sel_n == 2'd0 || sel_n == 2'd3) && (cnt_n <= LE);
        sh_c_n = (state_n == SHIFT) && (sel_n == 2'd1 || sel_n == 2'd3) && (cnt_n <= LC);
        sh_p_n = (state_n == SHIFT) && (sel_n == 2'd2 || sel_n == 2'd3) && (cnt_n <= LP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_q     <= '0;
            sr_e      <= '0;
            sr_c      <= '0;
            sr_p      <= '0;
            req_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            shift_e   <= 1'b0;
            shift_c   <= 1'b0;
            shift_p   <= 1'b0;
            load_e    <= 1'b0;
            load_c    <= 1'b0;
            load_p    <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            sel_q     <= sel_n;
            sr_e      <= sh_e_n ? src_e << 1 : src_e;
            sr_c      <= sh_c_n ? src_c << 1 : src_c;
            sr_p      <= sh_p_n ? src_p << 1 : src_p;
            req_ready <= state_n == IDLE;
            busy      <= state_n == SHIFT || state_n == CHECK;
            done      <= state_n == DONE;
            shift_e   <= sh_e_n;
            shift_c   <= sh_c_n;
            shift_p   <= sh_p_n;
            load_e    <= sh_e_n && src_e[E_W-1];
            load_c    <= sh_c_n && src_c[C_W-1];
            load_p    <= sh_p_n && src_p[P_W-1];
        end
    end

`ifdef LOADER_READBACK_CHECK_EN
    logic [E_W-1:0] lat_e;
    logic [C_W-1:0] lat_c;
    logic [P_W-1:0] lat_p;
    logic           mis;

    assign mis = ((sel_q == 2'd0 || sel_q == 2'd3) && out_e != lat_e) ||
                 ((sel_q == 2'd1 || sel_q == 2'd3) && out_c != lat_c) ||
                 ((sel_q == 2'd2 || sel_q == 2'd3) && out_p != lat_p);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lat_e     <= '0;
            lat_c     <= '0;
            lat_p     <= '0;
            check_err <= 1'b0;
        end else begin
            lat_e     <= accept ? req_e : lat_e;
            lat_c     <= accept ? req_c : lat_c;
            lat_p     <= accept ? req_p : lat_p;
            check_err <= accept ? 1'b0 : (state == CHECK) ? mis : check_err;
        end
    end
`else
    logic unused_readback;
    assign unused_readback = ^{out_e, out_c, out_p};
    assign check_err = 1'b0;
`endif
endmodule

// File: tb/tb_reg_serial_loader.sv
// tb_reg_serial_loader: directed checks of reg_serial_loader against bench models of reg_e/c/p.
module tb_reg_serial_loader;
`ifdef LOADER_READBACK_CHECK_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_sel = '0;
    logic [23:0] req_e = '0;
    logic [14:0] req_c = '0;
    logic [8:0]  req_p = '0;
    logic        load_e, load_c, load_p, shift_e, shift_c, shift_p;
    logic        busy, done, check_err;
    logic [23:0] reg_e = '0;
    logic [14:0] reg_c = '0;
    logic [8:0]  reg_p = '0;
    logic        p_stuck = 1'b0;

    logic [63:0] tr_se, tr_sc, tr_sp, tr_le, tr_lc, tr_lp, tr_bz, tr_rdy;
    int          done_at;
    logic        err_at_done;
    int          n_cmp = 0;
    int          n_bad = 0;

    reg_serial_loader dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_sel(req_sel),
        .req_e(req_e), .req_c(req_c), .req_p(req_p),
        .load_e(load_e), .load_c(load_c), .load_p(load_p),
        .shift_e(shift_e), .shift_c(shift_c), .shift_p(shift_p),
        .out_e(reg_e), .out_c(reg_c), .out_p(reg_p),
        .busy(busy), .done(done), .check_err(check_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (shift_e) reg_e <= {reg_e[22:0], load_e};
        if (shift_c) reg_c <= {reg_c[13:0], load_c};
        if (p_stuck) reg_p <= '0;
        else if (shift_p) reg_p <= {reg_p[7:0], load_p};
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ones(input int w);
        logic [63:0] r = '0;
        for (int i = 1; i <= w; i++) r[i] = 1'b1;
        return r;
    endfunction

    function automatic logic [63:0] msb_seq(input logic [63:0] v, input int w);
        logic [63:0] r = '0;
        for (int i = 1; i <= w; i++) r[i] = v[w-i];
        return r;
    endfunction

    task automatic start(input logic [1:0] sel, input logic [23:0] e, input logic [14:0] c,
                         input logic [8:0] p, input bit hold);
        int n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_before_req", 64'(req_ready), 64'd1);
        req_sel   = sel;
        req_e     = e;
        req_c     = c;
        req_p     = p;
        req_valid = 1'b1;
        @(negedge clk);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic trace();
        tr_se = '0; tr_sc = '0; tr_sp = '0; tr_le = '0; tr_lc = '0; tr_lp = '0;
        tr_bz = '0; tr_rdy = '0;
        done_at = -1;
        err_at_done = 1'b0;
        for (int k = 1; k < 60; k++) begin
            tr_se[k] = shift_e; tr_sc[k] = shift_c; tr_sp[k] = shift_p;
            tr_le[k] = load_e;  tr_lc[k] = load_c;  tr_lp[k] = load_p;
            tr_bz[k] = busy;    tr_rdy[k] = req_ready;
            if (done) begin
                done_at = k;
                err_at_done = check_err;
                return;
            end
            @(negedge clk);
        end
    endtask

    initial begin
        // Reset held with a pending request
        req_sel = 2'd0;
        req_e = 24'h123456;
        req_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("reset_outputs", 64'({req_ready, busy, done, check_err, shift_e, shift_c, shift_p,
                                     load_e, load_c, load_p}), 64'd0);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("ready_after_release", 64'(req_ready), 64'd1);
        chk("no_shift_after_release", 64'({shift_e, busy}), 64'd0);
        req_valid = 1'b0;
        @(negedge clk);
        chk("idle_no_shift", 64'({shift_e, shift_c, shift_p, busy}), 64'd0);

        // Single E load
        start(2'd0, 24'hA50F3C, 15'h0, 9'h0, 1'b0);
        trace();
        chk("e_done_at", 64'(done_at), 64'(25 + XL));
        chk("e_shift", tr_se, ones(24));
        chk("e_load_head", {56'd0, tr_le[8:1]}, 64'b10100101);
        chk("e_load", tr_le, msb_seq(64'h A50F3C, 24));
        chk("e_others_idle", tr_sc | tr_sp | tr_lc | tr_lp, 64'd0);
        chk("e_busy", tr_bz, ones(24 + XL));
        chk("e_reg", 64'(reg_e), 64'hA50F3C);
        @(negedge clk);
        chk("e_done_one_cycle", 64'({done, req_ready}), 64'b01);

        // All three at once
        start(2'd3, 24'hFFFFFF, 15'h0001, 9'h100, 1'b0);
        trace();
        chk("all_done_at", 64'(done_at), 64'(25 + XL));
        chk("all_shift_e", tr_se, ones(24));
        chk("all_shift_c", tr_sc, ones(15));
        chk("all_shift_p", tr_sp, ones(9));
        chk("all_load_e", tr_le, ones(24));
        chk("all_load_c", tr_lc, 64'h8000);
        chk("all_load_p", tr_lp, 64'h2);
        chk("all_regs", {reg_e, reg_c, reg_p}, {24'hFFFFFF, 15'h0001, 9'h100});

        // Request held high with new data during busy
        start(2'd1, 24'h0, 15'h2A5B, 9'h0, 1'b1);
        req_c = 15'h0F0F;
        trace();
        chk("hold_done_at", 64'(done_at), 64'(16 + XL));
        chk("hold_ready_low", tr_rdy, 64'd0);
        chk("hold_first_reg", 64'(reg_c), 64'h2A5B);
        @(negedge clk);
        chk("hold_ready_after_done", 64'({req_ready, shift_c}), 64'b10);
        chk("hold_first_reg_kept", 64'(reg_c), 64'h2A5B);
        @(negedge clk);
        req_valid = 1'b0;
        chk("hold_second_start", 64'({shift_c, load_c}), 64'b10);
        trace();
        chk("hold_second_reg", 64'(reg_c), 64'h0F0F);

        // Reset mid-operation at shift cycle 8
        @(negedge clk);
        start(2'd1, 24'h0, 15'h7ACE, 9'h0, 1'b0);
        repeat (7) @(negedge clk);
        chk("rst_mid_shifting", 64'({shift_c, busy}), 64'b11);
        rst = 1'b0;
        #1;
        chk("rst_mid_async", 64'({shift_c, load_c, busy, req_ready}), 64'd0);
        repeat (2) begin
            @(negedge clk);
            chk("rst_mid_no_done", 64'(done), 64'd0);
        end
        chk("rst_mid_partial", 64'(reg_c), 64'({8'h0F, 7'h7A}));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_ready", 64'({req_ready, done}), 64'b10);
        start(2'd1, 24'h0, 15'h1357, 9'h0, 1'b0);
        trace();
        chk("rst_mid_reload_done", 64'(done_at), 64'(16 + XL));
        chk("rst_mid_reload_load", tr_lc, msb_seq(64'h1357, 15));
        chk("rst_mid_reload_reg", 64'(reg_c), 64'h1357);

        // Readback: stuck register, then a working one
        p_stuck = 1'b1;
        @(negedge clk);
        start(2'd2, 24'h0, 15'h0, 9'h1AB, 1'b0);
        trace();
        chk("rb_stuck_done_at", 64'(done_at), 64'(10 + XL));
        chk("rb_stuck_err", 64'(err_at_done), 64'(XL));
        @(negedge clk);
        chk("rb_stuck_err_held", 64'(check_err), 64'(XL));
        p_stuck = 1'b0;
        start(2'd2, 24'h0, 15'h0, 9'h1AB, 1'b0);
        chk("rb_err_cleared", 64'(check_err), 64'd0);
        trace();
        chk("rb_ok_done_at", 64'(done_at), 64'(10 + XL));
        chk("rb_ok_err", 64'(err_at_done), 64'd0);
        chk("rb_ok_load", tr_lp, msb_seq(64'h1AB, 9));
        chk("rb_ok_reg", 64'(reg_p), 64'h1AB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
